// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS
//   common-anode digits. Each digit slot is a blanking gap of BLANK_CYC cycles
//   with every anode off. It is followed by a drive phase of DRIVE_CYC cycles
//   with the selected anode on. New display values are double-buffered and
//   are applied only at frame boundaries, so a frame never shows a mix of old
//   and new values.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high
//   digits_in   in   BCD codes, digit i = [4i+3:4i], digit 0 = rightmost
//   dp_in       in   decimal point request per digit (1 = lit)
//   digit_en    in   per-digit display enable (0 = blanked)
//   load        in   1-cycle strobe capturing digits_in/dp_in/digit_en
//   bcd_out     out  code for the shared decoder
//   dp_n        out  decimal point, active-low
//   an          out  anodes, active-low
//   frame_done  out  high during the last cycle of each frame
//   pending     out  loaded values waiting for the next frame boundary
//
// All outputs are registered. No input has a combinational path to any output.

module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BLANK_CYC  = 1000,
    parameter int DRIVE_CYC  = 99000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      load,
    output logic [3:0]                bcd_out,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done,
    output logic                      pending
);

    localparam int MAX_CYC = (BLANK_CYC > DRIVE_CYC) ? BLANK_CYC : DRIVE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_done_q, frame_done_d;
    logic                    pending_q, pending_d;

    // Active set: what the scan currently displays.
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;

    // Pending set: only meaningful while pending_q is set, so it needs no reset.
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;

    logic                    blank_last;
    logic                    drive_last;
    logic                    boundary;
    logic [IDX_W-1:0]        idx_next;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        an_d          = an_q;
        bcd_d         = bcd_q;
        dp_n_d        = dp_n_q;
        pending_d     = pending_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        act_en_d      = act_en_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_en_d     = pend_en_q;

        blank_last = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
        drive_last = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST);
        boundary   = drive_last && (idx_q == IDX_LAST);
        idx_next   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

        // A load in the boundary cycle goes straight to the active set, so
        // digit 0 of the next frame already shows it.
        if (load) begin
            if (boundary) begin
                act_digits_d = digits_in;
                act_dp_d     = dp_in;
                act_en_d     = digit_en;
                pending_d    = 1'b0;
            end else begin
                pend_digits_d = digits_in;
                pend_dp_d     = dp_in;
                pend_en_d     = digit_en;
                pending_d     = 1'b1;
            end
        end else if (boundary && pending_q) begin
            act_digits_d = pend_digits_q;
            act_dp_d     = pend_dp_q;
            act_en_d     = pend_en_q;
            pending_d    = 1'b0;
        end

        unique case (state_q)
            ST_BLANK: begin
                if (blank_last) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        an_d[i] = ~((idx_q == IDX_W'(i)) & act_en_q[i]);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (drive_last) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_next;
                    an_d    = '1;
                    // Decoder input and dp are settled here, at the start of
                    // the blanking gap, so they are stable before the anode turns on.
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (idx_next == IDX_W'(i)) begin
                            bcd_d  = act_digits_d[4*i +: 4];
                            dp_n_d = ~(act_dp_d[i] & act_en_d[i]);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Registered look-ahead: high while the scan sits in the last cycle of the frame.
        frame_done_d = (state_d == ST_DRIVE) && (cnt_d == DRIVE_LAST) &&
                       (idx_d == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            an_q         <= '1;
            bcd_q        <= '0;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            act_digits_q <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            bcd_q        <= bcd_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            act_digits_q <= act_digits_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_digits_q <= pend_digits_d;
        pend_dp_q     <= pend_dp_d;
        pend_en_q     <= pend_en_d;
    end

    assign bcd_out    = bcd_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl with NUM_DIGITS=4, BLANK_CYC=2, DRIVE_CYC=4.
// The reference model describes the display as a function of the number of
// clock edges since reset: slot = (k mod 24) / 6, and the anode is on for
// offsets 2..5 within the slot. The active and pending value sets are swapped
// at the last cycle of each frame.

module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int BC    = 2;
    localparam int DC    = 4;
    localparam int SLOT  = BC + DC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic [3:0]  bcd_out;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .BLANK_CYC (BC),
        .DRIVE_CYC (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .load      (load),
        .bcd_out   (bcd_out),
        .dp_n      (dp_n),
        .an        (an),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int          k;
    logic [15:0] m_act_dig, m_pend_dig;
    logic [3:0]  m_act_dp, m_act_en, m_pend_dp, m_pend_en;
    logic        m_pend;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [15:0] an_seq;   // expected an during the drive phase of slot i at [4i+3:4i]
        logic [15:0] bcd_seq;  // expected bcd_out in slot i
        logic [3:0]  dpn;      // expected dp_n in slot i at bit i
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, got, exp, k);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check all outputs.
    task automatic step();
        int p, s, w;
        logic [3:0] e_an;
        logic bnd;
        @(posedge clk);
        if (reset) begin
            k         = 0;
            m_act_dig = '0;
            m_act_dp  = '0;
            m_act_en  = '0;
            m_pend    = 1'b0;
        end else begin
            bnd = ((k % FRAME) == FRAME - 1);
            if (load) begin
                if (bnd) begin
                    m_act_dig = digits_in; m_act_dp = dp_in; m_act_en = digit_en;
                    m_pend    = 1'b0;
                end else begin
                    m_pend_dig = digits_in; m_pend_dp = dp_in; m_pend_en = digit_en;
                    m_pend     = 1'b1;
                end
            end else if (bnd && m_pend) begin
                m_act_dig = m_pend_dig; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
                m_pend    = 1'b0;
            end
            k++;
        end
        #1;
        p = k % FRAME;
        s = p / SLOT;
        w = p % SLOT;
        e_an = (w >= BC && m_act_en[s]) ? ~(4'b0001 << s) : 4'b1111;
        chk("m_an", {12'h0, an}, {12'h0, e_an});
        chk("m_bcd", {12'h0, bcd_out}, {12'h0, m_act_dig[4*s +: 4]});
        chk("m_dp_n", {15'h0, dp_n}, {15'h0, ~(m_act_dp[s] & m_act_en[s])});
        chk("m_frame_done", {15'h0, frame_done}, {15'h0, (p == FRAME - 1)});
        chk("m_pending", {15'h0, pending}, {15'h0, m_pend});
        load  = 1'b0;
        reset = 1'b0;
    endtask

    // Step until the frame position reaches target, bounded.
    task automatic run_to(input int target);
        for (int n = 0; n < 2 * FRAME; n++) begin
            if ((k % FRAME) == target) return;
            step();
        end
        n_chk++;
        n_err++;
        $display("FAIL run_to: position %0d not reached (k=%0d)", target, k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{dig: 16'h4321, dp: 4'b0000, en: 4'b1111,
                    an_seq: 16'h7BDE, bcd_seq: 16'h4321, dpn: 4'b1111};
        vecs[1] = '{dig: 16'h4321, dp: 4'b0010, en: 4'b1010,
                    an_seq: 16'h7FDF, bcd_seq: 16'h4321, dpn: 4'b1101};
        vecs[2] = '{dig: 16'hFA98, dp: 4'b1001, en: 4'b1111,
                    an_seq: 16'h7BDE, bcd_seq: 16'hFA98, dpn: 4'b0110};
        vecs[3] = '{dig: 16'h5678, dp: 4'b1111, en: 4'b0000,
                    an_seq: 16'hFFFF, bcd_seq: 16'h5678, dpn: 4'b1111};

        k = 0;
        m_pend_dig = '0; m_pend_dp = '0; m_pend_en = '0;
        m_act_dig = '0; m_act_dp = '0; m_act_en = '0; m_pend = 1'b0;
        digits_in = '0; dp_in = '0; digit_en = '0; load = 1'b0;

        // Reset state
        reset = 1'b1; step();
        reset = 1'b1; step();
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_bcd", {12'h0, bcd_out}, 16'h0);
        chk("rst_dp_n", {15'h0, dp_n}, 16'h1);
        chk("rst_frame_done", {15'h0, frame_done}, 16'h0);
        chk("rst_pending", {15'h0, pending}, 16'h0);

        // No load: dark display, frame_done every frame
        for (int i = 0; i < 3 * FRAME; i++) step();

        // Table-driven display patterns
        run_to(5);
        for (int v = 0; v < 4; v++) begin
            digits_in = vecs[v].dig; dp_in = vecs[v].dp; digit_en = vecs[v].en;
            load = 1'b1;
            step();
            chk("tbl_pending_set", {15'h0, pending}, 16'h1);
            run_to(0);
            chk("tbl_pending_clr", {15'h0, pending}, 16'h0);
            for (int s = 0; s < ND; s++) begin
                run_to(s * SLOT + 1);
                chk("tbl_blank_an", {12'h0, an}, 16'h000F);
                run_to(s * SLOT + BC + 1);
                chk("tbl_an", {12'h0, an}, {12'h0, vecs[v].an_seq[4*s +: 4]});
                chk("tbl_bcd", {12'h0, bcd_out}, {12'h0, vecs[v].bcd_seq[4*s +: 4]});
                chk("tbl_dp_n", {15'h0, dp_n}, {15'h0, vecs[v].dpn[s]});
            end
        end

        // Two loads in one frame: last one wins
        run_to(2);
        digits_in = 16'h1111; dp_in = 4'h0; digit_en = 4'hF; load = 1'b1;
        step();
        run_to(10);
        digits_in = 16'h2222; load = 1'b1;
        step();
        run_to(FRAME - 2);
        chk("dbl_pending_held", {15'h0, pending}, 16'h1);
        run_to(0);
        chk("dbl_pending_clr", {15'h0, pending}, 16'h0);
        for (int s = 0; s < ND; s++) begin
            run_to(s * SLOT + BC + 1);
            chk("dbl_bcd", {12'h0, bcd_out}, 16'h2);
        end

        // Load in the frame_done cycle takes effect on digit 0 immediately
        run_to(FRAME - 1);
        chk("fd_high", {15'h0, frame_done}, 16'h1);
        digits_in = 16'h0007; dp_in = 4'h0; digit_en = 4'hF; load = 1'b1;
        step();
        chk("fd_load_bcd", {12'h0, bcd_out}, 16'h7);
        chk("fd_load_pending", {15'h0, pending}, 16'h0);

        // Reset during digit 2 drive with a pending load
        digits_in = 16'h9999; load = 1'b1;
        step();
        run_to(2 * SLOT + BC + 1);
        chk("mid_pending", {15'h0, pending}, 16'h1);
        chk("mid_an_on", {12'h0, an}, 16'h000B);
        reset = 1'b1;
        step();
        chk("mid_rst_an", {12'h0, an}, 16'h000F);
        chk("mid_rst_bcd", {12'h0, bcd_out}, 16'h0);
        chk("mid_rst_pending", {15'h0, pending}, 16'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            chk("mid_dark", {12'h0, an}, 16'h000F);
        end

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            digit_en  = 4'($urandom);
            load      = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
